// File: rtl/pwm_ctrl_pkg.sv
// Shared types and defaults for the PWM duty-ramp controller.
package pwm_ctrl_pkg;

   localparam int unsigned DUTY_W_DEF = 8;

   typedef enum logic {
      IDLE = 1'b0,
      RAMP = 1'b1
   } state_e;

endpackage

// File: rtl/pwm_tick_gen.sv
// Update prescaler: counts 0..TICK_DIV-1 while enabled, held at 0 otherwise.
module pwm_tick_gen #(
   parameter int unsigned TICK_DIV = 256
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);
   localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign tick = en && (cnt_q == CNT_W'(TICK_DIV - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (!en || tick) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Ramps the PWM duty word toward a requested target by STEP every TICK_DIV clocks.
// Optional soft-stop (ramp to zero on stop) enabled by macro PWM_RAMP_SOFTSTOP_EN.
module pwm_ramp_ctrl
   import pwm_ctrl_pkg::*;
#(
   parameter int unsigned DUTY_W   = DUTY_W_DEF,
   parameter int unsigned STEP     = 4,
   parameter int unsigned TICK_DIV = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic [DUTY_W-1:0] req_duty,
`ifdef PWM_RAMP_SOFTSTOP_EN
   input  logic              stop,
`endif
   output logic              req_ready,
   output logic [DUTY_W-1:0] duty,
   output logic              busy,
   output logic              done
);
   localparam int unsigned DIFF_W = DUTY_W + 1;

   state_e            state_q, state_d;
   logic [DUTY_W-1:0] duty_q, duty_d;
   logic [DUTY_W-1:0] target_q, target_d;
   logic              done_q, done_d;
   logic              tick;
   logic              req_ready_c;
   logic [DUTY_W-1:0] target_eff;
   logic [DIFF_W-1:0] diff, mag;
   logic [DUTY_W-1:0] delta, step_duty;
   logic              down;

`ifdef PWM_RAMP_SOFTSTOP_EN
   logic stop_q;

   assign target_eff  = stop ? '0 : target_q;
   assign req_ready_c = (state_q == IDLE) && !stop;
`else
   assign target_eff  = target_q;
   assign req_ready_c = (state_q == IDLE);
`endif

   pwm_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .en   (state_q == RAMP),
      .tick (tick)
   );

   // Saturating step toward target; difference at DUTY_W+1 bits so sign is exact.
   always_comb begin
      diff = {1'b0, target_eff} - {1'b0, duty_q};
      down = diff[DIFF_W-1];
      mag  = down ? (DIFF_W'(0) - diff) : diff;
      if (mag > DIFF_W'(STEP)) begin
         delta = DUTY_W'(STEP);
      end else begin
         delta = DUTY_W'(mag);
      end
      step_duty = down ? (duty_q - delta) : (duty_q + delta);
   end

   always_comb begin
      state_d  = state_q;
      duty_d   = duty_q;
      target_d = target_eff;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid && req_ready_c) begin
               target_d = req_duty;
               if (req_duty == duty_q) begin
                  done_d = 1'b1;
               end else begin
                  state_d = RAMP;
               end
            end
`ifdef PWM_RAMP_SOFTSTOP_EN
            else if (stop && !stop_q && (duty_q != '0)) begin
               state_d = RAMP;
            end
`endif
         end
         RAMP: begin
            if (tick) begin
               duty_d = step_duty;
               if (step_duty == target_eff) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         duty_q   <= '0;
         target_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         duty_q   <= duty_d;
         target_q <= target_d;
         done_q   <= done_d;
      end
   end

`ifdef PWM_RAMP_SOFTSTOP_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         stop_q <= 1'b0;
      end else begin
         stop_q <= stop;
      end
   end
`endif

   assign req_ready = req_ready_c;
   assign duty      = duty_q;
   assign busy      = (state_q == RAMP);
   assign done      = done_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed + random bench for pwm_ramp_ctrl against a closed-form ramp trajectory model.
module tb_pwm_ramp_ctrl;

   localparam int unsigned DW     = 8;
   localparam int unsigned STEP_P = 4;
   localparam int unsigned TICK_P = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic [DW-1:0] req_duty;
   logic          stop;
   logic          req_ready;
   logic [DW-1:0] duty;
   logic          busy;
   logic          done;

   int    compared   = 0;
   int    mismatched = 0;
   int    cur        = 0;
   string phase      = "init";

   always #5 clk = ~clk;

   pwm_ramp_ctrl #(
      .DUTY_W   (DW),
      .STEP     (STEP_P),
      .TICK_DIV (TICK_P)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_duty  (req_duty),
`ifdef PWM_RAMP_SOFTSTOP_EN
      .stop      (stop),
`endif
      .req_ready (req_ready),
      .duty      (duty),
      .busy      (busy),
      .done      (done)
   );

   // Expected duty k clocks after the accepting edge: one STEP per TICK_P clocks, clamped at target.
   function automatic int exp_duty(input int s, input int t, input int k);
      int mv;
      mv = (k / int'(TICK_P)) * int'(STEP_P);
      if (t >= s) return (s + mv > t) ? t : s + mv;
      else        return (s - mv < t) ? t : s - mv;
   endfunction

   // Clock index (after accept) at which duty reaches target and done pulses.
   function automatic int done_k(input int s, input int t);
      int d;
      d = (t >= s) ? t - s : s - t;
      return int'(TICK_P) * ((d + int'(STEP_P) - 1) / int'(STEP_P));
   endfunction

   task automatic check(input string tag, input int obs, input int exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s [%s] observed=%0h expected=%0h", tag, phase, obs, exp);
      end
   endtask

   // Present a request at a negedge; returns just after the accepting posedge.
   task automatic accept(input int val);
      req_duty  = DW'(val);
      req_valid = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         if (req_ready) break;
         @(negedge clk);
      end
      check("accept_wait", int'(req_ready), 1);
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic follow(input int s, input int t, input int kmax);
      int d;
      d = done_k(s, t);
      for (int k = 0; k <= kmax; k++) begin
         @(negedge clk);
         check("duty",      int'(duty),      exp_duty(s, t, k));
         check("busy",      int'(busy),      (k < d) ? 1 : 0);
         check("done",      int'(done),      (k == d) ? 1 : 0);
         check("req_ready", int'(req_ready), (k >= d && !stop) ? 1 : 0);
      end
   endtask

   task automatic ramp(input int t);
      accept(t);
      follow(cur, t, done_k(cur, t) + 1);
      cur = t;
   endtask

   initial begin
      int t;
      rst       = 1'b0;
      req_valid = 1'b0;
      req_duty  = '0;
      stop      = 1'b0;
      repeat (2) @(negedge clk);
      phase = "reset";
      check("rst_duty",  int'(duty),      0);
      check("rst_busy",  int'(busy),      0);
      check("rst_done",  int'(done),      0);
      check("rst_ready", int'(req_ready), 1);
      rst = 1'b1;

      phase = "up_0x40";     ramp(8'h40);
      phase = "down_0x3e";   ramp(8'h3E);
      phase = "up_0xfc";     ramp(8'hFC);
      phase = "top_0xff";    ramp(8'hFF);
      phase = "equal_0xff";  ramp(8'hFF);

      phase = "random";
      for (int n = 0; n < 8; n++) begin
         t = int'($urandom_range(0, 255));
         ramp(t);
      end

      // Request offered mid-ramp is held off until the cycle after done.
      phase = "busy_hold";
      accept(8'h80);
      req_duty  = 8'h10;
      req_valid = 1'b1;
      follow(cur, 8'h80, done_k(cur, 8'h80));
      @(posedge clk);
      #1 req_valid = 1'b0;
      phase = "after_hold";
      follow(8'h80, 8'h10, done_k(8'h80, 8'h10) + 1);
      cur = 8'h10;

      // Reset mid-ramp abandons the ramp silently.
      phase = "mid_reset";
      accept(8'hF0);
      follow(cur, 8'hF0, 9);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("mr_duty",  int'(duty),      0);
      check("mr_ready", int'(req_ready), 1);
      check("mr_busy",  int'(busy),      0);
      check("mr_done",  int'(done),      0);
      rst = 1'b1;
      cur = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         check("post_rst_done", int'(done), 0);
         check("post_rst_duty", int'(duty), 0);
      end

`ifdef PWM_RAMP_SOFTSTOP_EN
      phase = "softstop";
      ramp(8'h80);
      stop = 1'b1;
      follow(8'h80, 0, done_k(8'h80, 0) + 1);
      check("ss_ready_held", int'(req_ready), 0);
      stop = 1'b0;
      cur  = 0;
      @(negedge clk);
      check("ss_ready_release", int'(req_ready), 1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
